// File: rtl/cal_ram_ctrl_if.sv
// Bus bundle between the calibration RAM controller and its clients:
// the I2C byte loader, the compute unit read port and the single-port RAM.
interface cal_ram_ctrl_if #(
    parameter int DATA_OPM_SZ = 16,
    parameter int ADDR_OPM_SZ = 4
);
    logic                   i_load_start;
    logic                   i_byte_vld;
    logic [7:0]             i_byte;
    logic                   o_load_done;
    logic                   o_ovf;
    logic                   i_rd_req;
    logic [ADDR_OPM_SZ-1:0] i_rd_addr;
    logic                   o_rd_ack;
    logic [DATA_OPM_SZ-1:0] o_rd_data;
    logic                   o_we;
    logic [ADDR_OPM_SZ-1:0] o_addr_opm;
    logic [DATA_OPM_SZ-1:0] o_data_wr_opm;
    logic [DATA_OPM_SZ-1:0] i_data_opm;

    modport slave (
        input  i_load_start, i_byte_vld, i_byte, i_rd_req, i_rd_addr, i_data_opm,
        output o_load_done, o_ovf, o_rd_ack, o_rd_data, o_we, o_addr_opm, o_data_wr_opm
    );

    modport master (
        output i_load_start, i_byte_vld, i_byte, i_rd_req, i_rd_addr, i_data_opm,
        input  o_load_done, o_ovf, o_rd_ack, o_rd_data, o_we, o_addr_opm, o_data_wr_opm
    );
endinterface

// File: rtl/cal_ram_ctrl.sv
// Packs the MSB-first calibration byte stream into words, writes them to consecutive
// RAM addresses and shares the single RAM port with word reads from the compute unit.
module cal_ram_ctrl #(
    parameter int DATA_OPM_SZ = 16,
    parameter int ADDR_OPM_SZ = 4,
    parameter int NUM_WORDS   = 11
) (
    input logic          clk,
    input logic          rst,
    cal_ram_ctrl_if.slave bus
);
    localparam int WP_SZ = ADDR_OPM_SZ + 1;

    typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_CAP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [WP_SZ-1:0]       r_wp;
    logic                   r_toggleLo;
    logic [7:0]             r_hi;
    logic [DATA_OPM_SZ-1:0] r_word;
    logic                   r_pend;
    logic                   r_done;
    logic                   r_ovf;
    logic [ADDR_OPM_SZ-1:0] r_addrQ;
    logic [ADDR_OPM_SZ-1:0] r_addrLast;
    logic                   r_rdAck;
    logic [DATA_OPM_SZ-1:0] r_rdData;

    logic                   w_byteTake;
    logic                   w_wordDone;
    logic                   w_wr;
    logic                   w_lastWr;
    logic                   w_we;
    logic [ADDR_OPM_SZ-1:0] w_addr;

    assign w_byteTake = bus.i_byte_vld && !bus.i_load_start && !r_done;
    assign w_wordDone = w_byteTake && r_toggleLo;
    assign w_wr       = (r_state == WR);
    assign w_lastWr   = w_wr && (r_wp == WP_SZ'(NUM_WORDS - 1));

    // A word completing while the previous one is being written is not a loss:
    // the RAM captures the old word at that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toggleLo <= 1'b0;
            r_hi       <= '0;
            r_word     <= '0;
            r_pend     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (bus.i_load_start) begin
            r_toggleLo <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            if (w_byteTake) begin
                if (!r_toggleLo) begin
                    r_hi       <= bus.i_byte;
                    r_toggleLo <= 1'b1;
                end else begin
                    r_word     <= {r_hi, bus.i_byte};
                    r_toggleLo <= 1'b0;
                end
            end
            if (w_lastWr) begin
                r_pend <= 1'b0;
            end else if (w_wordDone) begin
                r_pend <= 1'b1;
                if (r_pend && !w_wr) begin
                    r_ovf <= 1'b1;
                end
            end else if (w_wr) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wp       <= '0;
            r_done     <= 1'b0;
            r_addrQ    <= '0;
            r_addrLast <= '0;
            r_rdAck    <= 1'b0;
            r_rdData   <= '0;
        end else begin
            r_state    <= w_next;
            r_addrLast <= w_addr;
            r_rdAck    <= (r_state == RD_CAP);
            if (r_state == IDLE && w_next == RD_ADDR) begin
                r_addrQ <= bus.i_rd_addr;
            end
            if (r_state == RD_CAP) begin
                r_rdData <= (WP_SZ'(r_addrQ) >= WP_SZ'(NUM_WORDS)) ? '0 : bus.i_data_opm;
            end
            if (bus.i_load_start) begin
                r_wp   <= '0;
                r_done <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wp <= r_wp + WP_SZ'(1);
                end
                if (w_lastWr) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // A restart in the same cycle blocks the pending write so stale data never lands at address 0.
    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        w_addr = r_addrLast;
        case (r_state)
            IDLE: begin
                if (r_pend && !bus.i_load_start) begin
                    w_next = WR;
                end else if (bus.i_rd_req) begin
                    w_next = RD_ADDR;
                end
            end
            WR: begin
                w_we   = 1'b1;
                w_addr = r_wp[ADDR_OPM_SZ-1:0];
                w_next = IDLE;
            end
            RD_ADDR: begin
                w_addr = r_addrQ;
                w_next = RD_CAP;
            end
            RD_CAP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.o_we          = w_we;
    assign bus.o_addr_opm    = w_addr;
    assign bus.o_data_wr_opm = r_word;
    assign bus.o_load_done   = r_done;
    assign bus.o_ovf         = r_ovf;
    assign bus.o_rd_ack      = r_rdAck;
    assign bus.o_rd_data     = r_rdData;
endmodule

// File: tb/tb_cal_ram_ctrl.sv
// Self-checking bench for cal_ram_ctrl: a behavioural RAM on the bus and an
// expected-contents array built from the byte stream drive every comparison.
module tb_cal_ram_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    cal_ram_ctrl_if #(.DATA_OPM_SZ(DW), .ADDR_OPM_SZ(AW)) bus ();

    cal_ram_ctrl #(.DATA_OPM_SZ(DW), .ADDR_OPM_SZ(AW), .NUM_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    // RAM starts with recognisable garbage so out-of-range reads are distinguishable from zero.
    logic [DW-1:0] ramMem [16] = '{16'hDE00, 16'hDE01, 16'hDE02, 16'hDE03, 16'hDE04, 16'hDE05,
                                   16'hDE06, 16'hDE07, 16'hDE08, 16'hDE09, 16'hDE0A, 16'hDE0B,
                                   16'hDE0C, 16'hDE0D, 16'hDE0E, 16'hDE0F};
    logic [AW-1:0] ramAddrQ = '0;
    int writeCount = 0;
    int ackSeen = 0;
    logic [DW-1:0] expMem [16];

    always @(posedge clk) begin
        if (bus.o_we === 1'b1) begin
            ramMem[bus.o_addr_opm] <= bus.o_data_wr_opm;
            writeCount <= writeCount + 1;
        end
        ramAddrQ <= bus.o_addr_opm;
        if (bus.o_rd_ack === 1'b1) ackSeen <= ackSeen + 1;
    end
    assign bus.i_data_opm = ramMem[ramAddrQ];

    function automatic logic [DW-1:0] expRead(input int a);
        return (a >= NW) ? 16'h0000 : expMem[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.i_load_start = 1'b0;
        bus.i_byte_vld   = 1'b0;
        bus.i_byte       = 8'h00;
        bus.i_rd_req     = 1'b0;
        bus.i_rd_addr    = '0;
    endtask

    task automatic pulseStart();
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.i_byte_vld = 1'b1;
        bus.i_byte     = b;
        tick();
        bus.i_byte_vld = 1'b0;
    endtask

    task automatic doRead(input logic [AW-1:0] addr, output logic [DW-1:0] data, output int lat);
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = addr;
        lat  = -1;
        data = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.o_rd_ack === 1'b1) begin
                lat  = i;
                data = bus.o_rd_data;
                break;
            end
        end
        bus.i_rd_req = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        logic [63:0] packed0;
        packed0 = {bus.o_we, bus.o_addr_opm, bus.o_data_wr_opm, bus.o_load_done,
                   bus.o_ovf, bus.o_rd_ack, bus.o_rd_data};
        total++;
        if (packed0 !== 64'h0) begin
            bad++;
            $display("FAIL %s outputs: got we=%b addr=%h wd=%h done=%b ovf=%b ack=%b rd=%h want all 0",
                     tag, bus.o_we, bus.o_addr_opm, bus.o_data_wr_opm, bus.o_load_done,
                     bus.o_ovf, bus.o_rd_ack, bus.o_rd_data);
        end
    endtask

    task automatic test_reset();
        idleInputs();
        for (int i = 0; i < 16; i++) expMem[i] = 16'hDE00 + 16'(i);
        rst = 1'b1;
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();
        checkAllZero("after_reset");
    endtask

    task automatic test_load();
        int wc0;
        wc0 = writeCount;
        pulseStart();
        for (int i = 0; i < 2 * NW; i++) sendByte(8'(i + 1));
        for (int i = 0; i < NW; i++) expMem[i] = {8'(2 * i + 1), 8'(2 * i + 2)};
        total++;
        if (bus.o_load_done !== 1'b0) begin
            bad++;
            $display("FAIL load_done_early: got %b want 0", bus.o_load_done);
        end
        tick();
        tick();
        total++;
        if (bus.o_load_done !== 1'b1) begin
            bad++;
            $display("FAIL load_done: got %b want 1", bus.o_load_done);
        end
        total++;
        if (bus.o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL load_ovf: got %b want 0", bus.o_ovf);
        end
        total++;
        if (writeCount - wc0 != NW) begin
            bad++;
            $display("FAIL load_writes: got %0d want %0d", writeCount - wc0, NW);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (ramMem[i] !== expMem[i]) begin
                bad++;
                $display("FAIL load_mem[%0d]: got %h want %h", i, ramMem[i], expMem[i]);
            end
        end
    endtask

    task automatic test_read();
        logic [DW-1:0] d;
        int lat;
        logic [AW-1:0] addrs [2];
        addrs[0] = 4'd3;
        addrs[1] = 4'd12;
        for (int k = 0; k < 2; k++) begin
            doRead(addrs[k], d, lat);
            total++;
            if (lat != 3) begin
                bad++;
                $display("FAIL read_latency a=%0d: got %0d want 3", addrs[k], lat);
            end
            total++;
            if (d !== expRead(int'(addrs[k]))) begin
                bad++;
                $display("FAIL read_data a=%0d: got %h want %h", addrs[k], d, expRead(int'(addrs[k])));
            end
            tick();
            total++;
            if (bus.o_rd_ack !== 1'b0 || bus.o_rd_data !== d) begin
                bad++;
                $display("FAIL read_pulse_hold: got ack=%b data=%h want ack=0 data=%h", bus.o_rd_ack, bus.o_rd_data, d);
            end
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] d;
        int lat;
        pulseStart();
        sendByte(8'hA1);
        sendByte(8'hB2);
        expMem[0] = 16'hA1B2;
        doRead(4'd0, d, lat);
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL contention_latency: got %0d want 5", lat);
        end
        total++;
        if (d !== expMem[0]) begin
            bad++;
            $display("FAIL contention_data: got %h want %h", d, expMem[0]);
        end
    endtask

    task automatic test_overflow();
        int wc0;
        pulseStart();
        wc0 = writeCount;
        bus.i_rd_req   = 1'b1;
        bus.i_rd_addr  = 4'd5;
        bus.i_byte_vld = 1'b1;
        bus.i_byte     = 8'hC1;
        tick();
        bus.i_byte = 8'hC2;
        tick();
        bus.i_byte = 8'hD3;
        tick();
        total++;
        if (bus.o_rd_ack !== 1'b1 || bus.o_rd_data !== expRead(5)) begin
            bad++;
            $display("FAIL ovf_read: got ack=%b data=%h want ack=1 data=%h", bus.o_rd_ack, bus.o_rd_data, expRead(5));
        end
        bus.i_rd_req = 1'b0;
        bus.i_byte   = 8'hD4;
        tick();
        bus.i_byte_vld = 1'b0;
        total++;
        if (bus.o_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag: got %b want 1", bus.o_ovf);
        end
        tick();
        tick();
        expMem[0] = 16'hD3D4;
        total++;
        if (ramMem[0] !== expMem[0]) begin
            bad++;
            $display("FAIL ovf_mem0: got %h want %h", ramMem[0], expMem[0]);
        end
        total++;
        if (ramMem[1] !== expMem[1] || writeCount - wc0 != 1) begin
            bad++;
            $display("FAIL ovf_single_write: got mem1=%h writes=%0d want mem1=%h writes=1", ramMem[1], writeCount - wc0, expMem[1]);
        end
        pulseStart();
        total++;
        if (bus.o_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got %b want 1", bus.o_ovf);
        end
    endtask

    task automatic test_restart();
        logic [7:0] b [20];
        int wc0;
        pulseStart();
        for (int i = 0; i < 5; i++) sendByte(8'h31 + 8'(i));
        expMem[0] = 16'h3132;
        expMem[1] = 16'h3334;
        tick();
        tick();
        bus.i_load_start = 1'b1;
        bus.i_byte_vld   = 1'b1;
        bus.i_byte       = 8'h99;
        tick();
        bus.i_load_start = 1'b0;
        bus.i_byte_vld   = 1'b0;
        sendByte(8'h41);
        sendByte(8'h42);
        expMem[0] = 16'h4142;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ramMem[i] !== expMem[i]) begin
                bad++;
                $display("FAIL restart_mem[%0d]: got %h want %h", i, ramMem[i], expMem[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            b[i] = 8'($urandom);
            sendByte(b[i]);
        end
        for (int i = 0; i < 10; i++) expMem[i + 1] = {b[2 * i], b[2 * i + 1]};
        tick();
        tick();
        total++;
        if (bus.o_load_done !== 1'b1) begin
            bad++;
            $display("FAIL restart_done: got %b want 1", bus.o_load_done);
        end
        wc0 = writeCount;
        sendByte(8'hEE);
        sendByte(8'hEF);
        sendByte(8'hF0);
        tick();
        tick();
        total++;
        if (writeCount != wc0 || bus.o_load_done !== 1'b1) begin
            bad++;
            $display("FAIL extra_bytes: got writes=%0d done=%b want writes=0 done=1", writeCount - wc0, bus.o_load_done);
        end
        for (int i = 0; i < NW; i++) begin
            total++;
            if (ramMem[i] !== expMem[i]) begin
                bad++;
                $display("FAIL restart_full_mem[%0d]: got %h want %h", i, ramMem[i], expMem[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ack0;
        pulseStart();
        sendByte(8'h61);
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 4'd2;
        tick();
        rst = 1'b1;
        #1;
        checkAllZero("mid_reset");
        ack0 = ackSeen;
        bus.i_rd_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if (ackSeen != ack0) begin
            bad++;
            $display("FAIL mid_reset_ack: got %0d acks want 0", ackSeen - ack0);
        end
        sendByte(8'h71);
        sendByte(8'h72);
        expMem[0] = 16'h7172;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ramMem[i] !== expMem[i]) begin
                bad++;
                $display("FAIL mid_reset_mem[%0d]: got %h want %h", i, ramMem[i], expMem[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int t [2];
        logic [DW-1:0] d [2];
        n = 0;
        t[0] = -1;
        t[1] = -1;
        d[0] = '0;
        d[1] = '0;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 4'd7;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (bus.o_rd_ack === 1'b1) begin
                t[n] = i;
                d[n] = bus.o_rd_data;
                n++;
                if (n == 2) break;
            end
        end
        bus.i_rd_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (t[k] != 3 * (k + 1) || d[k] !== expRead(7)) begin
                bad++;
                $display("FAIL b2b_ack%0d: got t=%0d data=%h want t=%0d data=%h", k, t[k], d[k], 3 * (k + 1), expRead(7));
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] b [2 * NW];
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int lat;
        for (int r = 0; r < 3; r++) begin
            pulseStart();
            for (int i = 0; i < 2 * NW; i++) begin
                b[i] = 8'($urandom);
                sendByte(b[i]);
                repeat ($urandom_range(0, 2)) tick();
            end
            for (int i = 0; i < NW; i++) expMem[i] = {b[2 * i], b[2 * i + 1]};
            repeat (4) tick();
            total++;
            if (bus.o_load_done !== 1'b1) begin
                bad++;
                $display("FAIL rand_done r=%0d: got %b want 1", r, bus.o_load_done);
            end
            for (int k = 0; k < 8; k++) begin
                a = AW'($urandom_range(0, 15));
                doRead(a, d, lat);
                total++;
                if (lat != 3 || d !== expRead(int'(a))) begin
                    bad++;
                    $display("FAIL rand_read a=%0d: got lat=%0d data=%h want lat=3 data=%h", a, lat, d, expRead(int'(a)));
                end
                repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_load();
        test_read();
        test_contention();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end
endmodule
